// File: rtl/stoch_signed_matmul.sv
// -----------------------------------------------------------------------------
// stoch_signed_matmul
//   Signed stochastic matrix multiplier, Y = A x B, on bipolar bitstreams that
//   are split into a positive and a negative channel. Each output element runs
//   its own signed counter-based adder: the per-cycle net product count is
//   added to a residue accumulator, and a threshold step (T = 1 unscaled,
//   T = NUM_MID scaled) converts it into at most one output pulse per cycle on
//   either the positive or the negative channel. The accumulator saturates
//   symmetrically, and any clip sets a sticky overflow flag.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   nRST       asynchronous active-low reset
//   EN         advance enable; low holds accumulators, outputs and OVF
//   CLR        synchronous clear of accumulators, outputs and OVF (beats EN)
//   A_p, A_m   [NUM_ROWS][NUM_MID]  positive / negative bits of A
//   B_p, B_m   [NUM_MID][NUM_COLS]  positive / negative bits of B
//   Y_p, Y_m   [NUM_ROWS][NUM_COLS] registered positive / negative bits of Y
//   OVF        sticky: some accumulator clipped since last reset or CLR
// -----------------------------------------------------------------------------
module stoch_signed_matmul #(
    parameter int NUM_ROWS = 2,
    parameter int NUM_MID  = 2,
    parameter int NUM_COLS = 2,
    parameter int SCALED   = 0,
    parameter int ACC_W    = 8
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               EN,
    input  logic                               CLR,
    input  logic [NUM_ROWS-1:0][NUM_MID-1:0]   A_p,
    input  logic [NUM_ROWS-1:0][NUM_MID-1:0]   A_m,
    input  logic [NUM_MID-1:0][NUM_COLS-1:0]   B_p,
    input  logic [NUM_MID-1:0][NUM_COLS-1:0]   B_m,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y_p,
    output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y_m,
    output logic                               OVF
);

    // One extra bit of headroom: acc + s cannot overflow SW bits as long as
    // 2^(ACC_W-1)-1 >= 2*NUM_MID + T, which is checked below.
    localparam int SW = ACC_W + 1;
    localparam int T  = (SCALED != 0) ? NUM_MID : 1;
    localparam logic signed [SW-1:0] T_S   = SW'(T);
    localparam logic signed [SW-1:0] LIM_S = SW'((2 ** (ACC_W - 1)) - 1);

    if (((2 ** (ACC_W - 1)) - 1) < (2 * NUM_MID + T)) begin : g_bad_acc_w
        $error("stoch_signed_matmul: ACC_W too small for NUM_MID/threshold");
    end

    logic [NUM_ROWS-1:0][NUM_COLS-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]            yp_q, yp_d;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]            ym_q, ym_d;
    logic                                         ovf_q, ovf_d;
    logic signed [SW-1:0]                         s_v;
    logic signed [SW-1:0]                         t_v;

    always_comb begin
        acc_d = acc_q;
        yp_d  = '0;
        ym_d  = '0;
        ovf_d = ovf_q;
        s_v   = '0;
        t_v   = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int j = 0; j < NUM_COLS; j++) begin
                // Like-signed products add, mixed-signed products subtract, so
                // simultaneous pos/neg terms cancel before thresholding.
                s_v = '0;
                for (int k = 0; k < NUM_MID; k++) begin
                    s_v = s_v + SW'(A_p[i][k] & B_p[k][j])
                              + SW'(A_m[i][k] & B_m[k][j])
                              - SW'(A_p[i][k] & B_m[k][j])
                              - SW'(A_m[i][k] & B_p[k][j]);
                end
                t_v = {acc_q[i][j][ACC_W-1], acc_q[i][j]} + s_v;
                if (t_v >= T_S) begin
                    yp_d[i][j] = 1'b1;
                    t_v        = t_v - T_S;
                end else if (t_v <= -T_S) begin
                    ym_d[i][j] = 1'b1;
                    t_v        = t_v + T_S;
                end
                if (t_v > LIM_S) begin
                    t_v   = LIM_S;
                    ovf_d = 1'b1;
                end else if (t_v < -LIM_S) begin
                    t_v   = -LIM_S;
                    ovf_d = 1'b1;
                end
                acc_d[i][j] = t_v[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc_q <= '0;
            yp_q  <= '0;
            ym_q  <= '0;
            ovf_q <= 1'b0;
        end else if (CLR) begin
            acc_q <= '0;
            yp_q  <= '0;
            ym_q  <= '0;
            ovf_q <= 1'b0;
        end else if (EN) begin
            acc_q <= acc_d;
            yp_q  <= yp_d;
            ym_q  <= ym_d;
            ovf_q <= ovf_d;
        end
    end

    assign Y_p = yp_q;
    assign Y_m = ym_q;
    assign OVF = ovf_q;

endmodule

// File: tb/tb_stoch_signed_matmul.sv
// -----------------------------------------------------------------------------
// tb_stoch_signed_matmul
//   Three instances: 2x2x2 unscaled, 2x2x2 scaled, 3x4x2 scaled. One instance
//   is exercised at a time; a bench-side model of the signed counter adder
//   pushes the expected outputs for each driven cycle onto a queue, and the
//   entry is popped and compared once the DUT has registered that cycle.
// -----------------------------------------------------------------------------
module tb_stoch_signed_matmul;

    localparam int LIM = 127;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    logic EN = 1'b0;
    logic CLR = 1'b0;

    always #5 CLK = ~CLK;

    logic [1:0][1:0] a0p, a0m, b0p, b0m, y0p, y0m;
    logic            ovf0;
    logic [1:0][1:0] a1p, a1m, b1p, b1m, y1p, y1m;
    logic            ovf1;
    logic [2:0][3:0] a2p, a2m;
    logic [3:0][1:0] b2p, b2m;
    logic [2:0][1:0] y2p, y2m;
    logic            ovf2;

    stoch_signed_matmul #(.NUM_ROWS(2), .NUM_MID(2), .NUM_COLS(2), .SCALED(0), .ACC_W(8)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .EN(EN), .CLR(CLR),
        .A_p(a0p), .A_m(a0m), .B_p(b0p), .B_m(b0m),
        .Y_p(y0p), .Y_m(y0m), .OVF(ovf0));

    stoch_signed_matmul #(.NUM_ROWS(2), .NUM_MID(2), .NUM_COLS(2), .SCALED(1), .ACC_W(8)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .EN(EN), .CLR(CLR),
        .A_p(a1p), .A_m(a1m), .B_p(b1p), .B_m(b1m),
        .Y_p(y1p), .Y_m(y1m), .OVF(ovf1));

    stoch_signed_matmul #(.NUM_ROWS(3), .NUM_MID(4), .NUM_COLS(2), .SCALED(1), .ACC_W(8)) u_dut2 (
        .CLK(CLK), .nRST(nRST), .EN(EN), .CLR(CLR),
        .A_p(a2p), .A_m(a2m), .B_p(b2p), .B_m(b2m),
        .Y_p(y2p), .Y_m(y2m), .OVF(ovf2));

    // Model state (sized for the largest instance).
    int ap [3][4];
    int am [3][4];
    int bp [4][2];
    int bm [4][2];
    int macc [3][2];
    int myp, mym;
    bit movf;
    int msel, mR, mM, mC, mT;
    int ysum [3][2];

    typedef struct {
        int yp;
        int ym;
        bit ovf;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                macc[i][j] = 0;
                ysum[i][j] = 0;
            end
            for (int k = 0; k < 4; k++) begin
                ap[i][k] = 0;
                am[i][k] = 0;
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 2; j++) begin
                bp[k][j] = 0;
                bm[k][j] = 0;
            end
        end
        myp = 0;
        mym = 0;
        movf = 1'b0;
    endtask

    task automatic select(input int sel);
        msel = sel;
        case (sel)
            0: begin mR = 2; mM = 2; mC = 2; mT = 1; end
            1: begin mR = 2; mM = 2; mC = 2; mT = 2; end
            default: begin mR = 3; mM = 4; mC = 2; mT = 4; end
        endcase
    endtask

    task automatic drive_inputs();
        a0p = '0; a0m = '0; b0p = '0; b0m = '0;
        a1p = '0; a1m = '0; b1p = '0; b1m = '0;
        a2p = '0; a2m = '0; b2p = '0; b2m = '0;
        for (int i = 0; i < mR; i++) begin
            for (int k = 0; k < mM; k++) begin
                case (msel)
                    0: begin a0p[i][k] = ap[i][k][0]; a0m[i][k] = am[i][k][0]; end
                    1: begin a1p[i][k] = ap[i][k][0]; a1m[i][k] = am[i][k][0]; end
                    default: begin a2p[i][k] = ap[i][k][0]; a2m[i][k] = am[i][k][0]; end
                endcase
            end
        end
        for (int k = 0; k < mM; k++) begin
            for (int j = 0; j < mC; j++) begin
                case (msel)
                    0: begin b0p[k][j] = bp[k][j][0]; b0m[k][j] = bm[k][j][0]; end
                    1: begin b1p[k][j] = bp[k][j][0]; b1m[k][j] = bm[k][j][0]; end
                    default: begin b2p[k][j] = bp[k][j][0]; b2m[k][j] = bm[k][j][0]; end
                endcase
            end
        end
    endtask

    task automatic model_step();
        int s, t, nyp, nym;
        if (CLR) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 2; j++)
                    macc[i][j] = 0;
            myp = 0;
            mym = 0;
            movf = 1'b0;
        end else if (EN) begin
            nyp = 0;
            nym = 0;
            for (int i = 0; i < mR; i++) begin
                for (int j = 0; j < mC; j++) begin
                    s = 0;
                    for (int k = 0; k < mM; k++)
                        s += ap[i][k] * bp[k][j] + am[i][k] * bm[k][j]
                           - ap[i][k] * bm[k][j] - am[i][k] * bp[k][j];
                    t = macc[i][j] + s;
                    if (t >= mT) begin
                        nyp |= (1 << (i * mC + j));
                        t -= mT;
                    end else if (t <= -mT) begin
                        nym |= (1 << (i * mC + j));
                        t += mT;
                    end
                    if (t > LIM) begin t = LIM; movf = 1'b1; end
                    else if (t < -LIM) begin t = -LIM; movf = 1'b1; end
                    macc[i][j] = t;
                end
            end
            myp = nyp;
            mym = nym;
        end
    endtask

    // One clock: drive, predict, wait for the edge, compare.
    task automatic cycle(input string tag);
        exp_t e;
        int oyp, oym;
        logic oovf;
        drive_inputs();
        model_step();
        e.yp = myp;
        e.ym = mym;
        e.ovf = movf;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        case (msel)
            0: begin oyp = int'(y0p); oym = int'(y0m); oovf = ovf0; end
            1: begin oyp = int'(y1p); oym = int'(y1m); oovf = ovf1; end
            default: begin
                oyp = int'(y2p); oym = int'(y2m); oovf = ovf2;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 2; j++)
                        ysum[i][j] += int'(y2p[i][j]) - int'(y2m[i][j]);
            end
        endcase
        n_chk++;
        if (oyp !== e.yp || oym !== e.ym || oovf !== e.ovf || (oyp & oym) != 0)
            $display("FAIL %s t=%0t: got Y_p=%0h Y_m=%0h OVF=%b, want Y_p=%0h Y_m=%0h OVF=%b",
                     tag, $time, oyp, oym, oovf, e.yp, e.ym, e.ovf);
        else
            n_pass++;
    endtask

    task automatic clear_pulse();
        CLR = 1'b1;
        cycle("clear");
        CLR = 1'b0;
    endtask

    task automatic test_reset();
        EN = 1'b1;
        nRST = 1'b0;
        repeat (4) begin
            a0p = 4'($urandom); a0m = 4'($urandom); b0p = 4'($urandom); b0m = 4'($urandom);
            a1p = 4'($urandom); a1m = 4'($urandom); b1p = 4'($urandom); b1m = 4'($urandom);
            a2p = 12'($urandom); a2m = 12'($urandom); b2p = 8'($urandom); b2m = 8'($urandom);
            @(posedge CLK);
            #1;
            n_chk++;
            if ({y0p, y0m, ovf0, y1p, y1m, ovf1, y2p, y2m, ovf2} !== '0)
                $display("FAIL reset_hold: got %0h, want 0",
                         {y0p, y0m, ovf0, y1p, y1m, ovf1, y2p, y2m, ovf2});
            else
                n_pass++;
        end
        @(negedge CLK);
        model_clear();
        for (int s = 0; s < 3; s++) begin
            select(s);
            drive_inputs();
        end
        nRST = 1'b1;
        repeat (6) begin
            @(posedge CLK);
            #1;
            n_chk++;
            if ({y0p, y0m, ovf0, y1p, y1m, ovf1, y2p, y2m, ovf2} !== '0)
                $display("FAIL reset_release: got %0h, want 0",
                         {y0p, y0m, ovf0, y1p, y1m, ovf1, y2p, y2m, ovf2});
            else
                n_pass++;
        end
    endtask

    task automatic test_unscaled_positive();
        select(0);
        model_clear();
        EN = 1'b1;
        clear_pulse();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2; k++) begin
                ap[i][k] = 1;
                bp[k][i] = 1;
            end
        for (int n = 1; n <= 132; n++) begin
            cycle("unscaled_pos");
            if (n == 127) begin
                n_chk++;
                if (ovf0 !== 1'b0) $display("FAIL ovf_before_clip: got %b, want 0", ovf0);
                else n_pass++;
            end
            if (n == 128) begin
                n_chk++;
                if (ovf0 !== 1'b1 || y0p !== 4'hF) $display("FAIL ovf_at_clip: got OVF=%b Y_p=%h, want 1/f", ovf0, y0p);
                else n_pass++;
            end
        end
    endtask

    // Runs straight after the saturation test so OVF is set on entry.
    task automatic test_en_clr();
        int hold_p, hold_m;
        select(0);
        EN = 1'b1;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2; k++) begin
                ap[i][k] = 0; am[i][k] = 0; bp[k][i] = 0; bm[k][i] = 0;
            end
        ap[0][0] = 1; ap[0][1] = 1; am[1][0] = 1;
        bp[0][0] = 1; bp[0][1] = 1; bp[1][0] = 1; bm[1][1] = 1;
        repeat (10) cycle("en_run");
        hold_p = int'(y0p);
        hold_m = int'(y0m);
        EN = 1'b0;
        repeat (5) begin
            cycle("en_hold");
            n_chk++;
            if (int'(y0p) !== hold_p || int'(y0m) !== hold_m || ovf0 !== 1'b1)
                $display("FAIL en_freeze: got Y_p=%h Y_m=%h OVF=%b, want %h %h 1",
                         y0p, y0m, ovf0, hold_p, hold_m);
            else
                n_pass++;
        end
        CLR = 1'b1;
        cycle("clr_en0");
        n_chk++;
        if (y0p !== 4'h0 || y0m !== 4'h0 || ovf0 !== 1'b0)
            $display("FAIL clr_en0: got Y_p=%h Y_m=%h OVF=%b, want 0 0 0", y0p, y0m, ovf0);
        else
            n_pass++;
        CLR = 1'b0;
        EN = 1'b1;
        repeat (10) cycle("post_clr");
        CLR = 1'b1;
        cycle("clr_over_en");
        CLR = 1'b0;
    endtask

    task automatic test_cancellation();
        select(0);
        model_clear();
        EN = 1'b1;
        clear_pulse();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 2; k++) begin
                ap[i][k] = 1; am[i][k] = 1; bp[k][i] = 1;
            end
        repeat (40) cycle("cancel");
        n_chk++;
        if (y0p !== 4'h0 || y0m !== 4'h0 || ovf0 !== 1'b0)
            $display("FAIL cancel_end: got Y_p=%h Y_m=%h OVF=%b, want 0 0 0", y0p, y0m, ovf0);
        else
            n_pass++;
    endtask

    task automatic test_scaled_sign();
        select(1);
        model_clear();
        EN = 1'b1;
        clear_pulse();
        am[0][0] = 1; am[0][1] = 1;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++)
                bp[k][j] = 1;
        repeat (8) begin
            cycle("scaled_neg2");
            n_chk++;
            if (y1m[0] !== 2'b11 || y1p !== 4'h0)
                $display("FAIL scaled_neg2_row: got Y_m=%h Y_p=%h, want row0 Y_m=3, Y_p=0", y1m, y1p);
            else
                n_pass++;
        end
        am[0][1] = 0;
        for (int n = 0; n < 8; n++) begin
            cycle("scaled_neg1");
            n_chk++;
            if (y1m[0][0] !== n[0] || y1p !== 4'h0)
                $display("FAIL scaled_toggle: got Y_m[0][0]=%b Y_p=%h, want %b and 0", y1m[0][0], y1p, n[0]);
            else
                n_pass++;
        end
    endtask

    task automatic test_random();
        int pap [3][4];
        int pam [3][4];
        int pbp [4][2];
        int pbm [4][2];
        real ref_v, dens;
        select(2);
        model_clear();
        EN = 1'b1;
        clear_pulse();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
                pap[i][k] = 100 + ((i * 4 + k) * 173) % 800;
                pam[i][k] = 50 + ((i * 4 + k) * 311) % 500;
            end
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 2; j++) begin
                pbp[k][j] = 80 + ((k * 2 + j) * 257) % 850;
                pbm[k][j] = 30 + ((k * 2 + j) * 149) % 600;
            end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 2; j++)
                ysum[i][j] = 0;
        repeat (4096) begin
            for (int i = 0; i < 3; i++)
                for (int k = 0; k < 4; k++) begin
                    ap[i][k] = ($urandom_range(0, 999) < pap[i][k]) ? 1 : 0;
                    am[i][k] = ($urandom_range(0, 999) < pam[i][k]) ? 1 : 0;
                end
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 2; j++) begin
                    bp[k][j] = ($urandom_range(0, 999) < pbp[k][j]) ? 1 : 0;
                    bm[k][j] = ($urandom_range(0, 999) < pbm[k][j]) ? 1 : 0;
                end
            cycle("random");
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 2; j++) begin
                ref_v = 0.0;
                for (int k = 0; k < 4; k++)
                    ref_v += (real'(pap[i][k] - pam[i][k]) / 1000.0) *
                             (real'(pbp[k][j] - pbm[k][j]) / 1000.0);
                ref_v = ref_v / 4.0;
                dens = real'(ysum[i][j]) / 4096.0;
                n_chk++;
                if (dens - ref_v > 0.03 || ref_v - dens > 0.03)
                    $display("FAIL density[%0d][%0d]: got %f, want %f +/- 0.03", i, j, dens, ref_v);
                else
                    n_pass++;
            end
    endtask

    initial begin
        model_clear();
        select(0);
        test_reset();
        test_unscaled_positive();
        test_en_clr();
        test_cancellation();
        test_scaled_sign();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
